// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seg_scan_driver_pkg;

    localparam int unsigned DEFAULT_DIGITS      = 4;
    localparam int unsigned DEFAULT_REFRESH_DIV = 100000;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/seg_scan_driver_tick.sv
// scan_tick_gen: free-running prescaler, single-cycle tick every REFRESH_DIV clocks.
module scan_tick_gen
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned     CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed digit scanner with shadow buffer committed at frame wrap (tear-free).
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS      = DEFAULT_DIGITS,
    parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [DIGITS-1:0]     in_dp,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);

    localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic                 tick;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  display_q, display_d;
    logic [DIGITS-1:0]    dp_reg_q, dp_reg_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic                 pending_q, pending_d;
    logic [DIGITS-1:0]    an_q, an_d;
    nibble_t              nibble_q, nibble_d;
    logic                 dp_q, dp_d;
    logic [DIGITS-1:0]    blank;
    logic                 wrap;
    logic                 commit;
    logic                 capture;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign in_ready = !pending_q;
    assign nibble   = nibble_q;
    assign an       = an_q;
    assign dp       = dp_q;

    // Capture needs !pending, commit needs pending: never both in one cycle.
    always_comb begin
        wrap        = tick && (idx_q == LAST_IDX);
        commit      = wrap && pending_q;
        capture     = in_valid && !pending_q;
        idx_d       = idx_q;
        display_d   = display_q;
        dp_reg_d    = dp_reg_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        if (capture) begin
            shadow_d    = in_data;
            shadow_dp_d = in_dp;
            pending_d   = 1'b1;
        end
        if (commit) begin
            display_d = shadow_q;
            dp_reg_d  = shadow_dp_q;
            pending_d = 1'b0;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic zero_above;

    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            zero_above = zero_above & (display_d[4*(DIGITS-1-k) +: 4] == 4'h0);
            blank[DIGITS-1-k] = zero_above;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    // Outputs use the post-commit display so new data first shows at digit 0.
    always_comb begin
        an_d     = an_q;
        nibble_d = nibble_q;
        dp_d     = dp_q;
        if (tick) begin
            an_d = '1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    nibble_d = display_d[4*i +: 4];
                    dp_d     = ~dp_reg_d[i];
                    an_d[i]  = blank[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= LAST_IDX;
            display_q   <= '0;
            dp_reg_q    <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            an_q        <= '1;
            nibble_q    <= '0;
            dp_q        <= 1'b1;
        end else begin
            idx_q       <= idx_d;
            display_q   <= display_d;
            dp_reg_q    <= dp_reg_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            nibble_q    <= nibble_d;
            dp_q        <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized + directed bench for seg_scan_driver against a frame-level reference model.
module tb_seg_scan_driver;

    localparam int unsigned DIGITS      = 4;
    localparam int unsigned REFRESH_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_dp;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model state
    int          m_cycle;
    int          m_idx;
    int          m_disp [4];
    bit          m_dpr  [4];
    int          m_shad [4];
    bit          m_shdp [4];
    bit          m_pend;
    bit          m_tick;
    bit          m_captured;
    logic [3:0]  e_an;
    logic [3:0]  e_nib;
    logic        e_dp;

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dp    (in_dp),
        .nibble   (nibble),
        .an       (an),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit slot_blank(int s);
        bit all_zero;
        all_zero = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (s == 0) return 1'b0;
        for (int j = s; j < 4; j++) if (m_disp[j] != 0) all_zero = 1'b0;
        return all_zero;
`else
        all_zero = 1'b0;
        return all_zero;
`endif
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit commit;
        m_tick     = 1'b0;
        m_captured = 1'b0;
        if (!rst_n) begin
            m_cycle = 0;
            m_idx   = 3;
            m_pend  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_disp[i] = 0; m_dpr[i] = 0; m_shad[i] = 0; m_shdp[i] = 0;
            end
            e_an  = 4'hF;
            e_nib = 4'h0;
            e_dp  = 1'b1;
            return;
        end
        m_tick  = (m_cycle % REFRESH_DIV) == REFRESH_DIV - 1;
        m_cycle = m_cycle + 1;
        commit  = m_tick && m_idx == 3 && m_pend;
        if (in_valid && !m_pend) begin
            for (int i = 0; i < 4; i++) begin
                m_shad[i] = (in_data >> (4 * i)) & 16'hF;
                m_shdp[i] = in_dp[i];
            end
            m_pend     = 1'b1;
            m_captured = 1'b1;
        end else if (commit) begin
            for (int i = 0; i < 4; i++) begin
                m_disp[i] = m_shad[i];
                m_dpr[i]  = m_shdp[i];
            end
            m_pend = 1'b0;
        end
        if (m_tick) begin
            m_idx = (m_idx + 1) % 4;
            e_nib = 4'(m_disp[m_idx]);
            e_dp  = !m_dpr[m_idx];
            e_an  = slot_blank(m_idx) ? 4'hF : (4'hF & ~(4'h1 << m_idx));
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_eq("an", {28'h0, an}, {28'h0, e_an});
            check_eq("nibble", {28'h0, nibble}, {28'h0, e_nib});
            check_eq("dp", {31'h0, dp}, {31'h0, e_dp});
            check_eq("in_ready", {31'h0, in_ready}, {31'h0, !m_pend});
        end
    endtask

    // Run until the model's tick lands on slot s (at least one cycle).
    task automatic run_to_slot(input int s);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            cyc(1);
            if (m_tick && m_idx == s) found = 1'b1;
        end
        check_eq("slot_wait", {31'h0, found}, 32'h1);
    endtask

    task automatic write_value(input logic [15:0] v, input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = v;
        in_dp    = d;
        cyc(1);
        in_valid = 1'b0;
        check_eq("ready_low_after_write", {31'h0, in_ready}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check_eq("rst_an", {28'h0, an}, 32'hF);
        check_eq("rst_nibble", {28'h0, nibble}, 32'h0);
        check_eq("rst_dp", {31'h0, dp}, 32'h1);
        check_eq("rst_ready", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic [3:0] frame_nib [4];
        logic [3:0] frame_an  [4];
        logic       frame_dp  [4];
        bit         got_it;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dp    = '0;
        m_cycle  = 0;
        m_idx    = 3;
        m_pend   = 1'b0;

        // Reset and first tick at cycle 4 selects digit 0
        do_reset();
        cyc(3);
        check_eq("pre_tick_an", {28'h0, an}, 32'hF);
        cyc(1);
        check_eq("first_tick_an", {28'h0, an}, 32'hE);
        check_eq("first_tick_nibble", {28'h0, nibble}, 32'h0);

        // Mid-frame write of 1234; old data until wrap
        cyc(5);
        write_value(16'h1234, 4'b0000);
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_nib[s] = nibble;
        end
        check_eq("f1234_s0", {28'h0, frame_nib[0]}, 32'h4);
        check_eq("f1234_s1", {28'h0, frame_nib[1]}, 32'h3);
        check_eq("f1234_s2", {28'h0, frame_nib[2]}, 32'h2);
        check_eq("f1234_s3", {28'h0, frame_nib[3]}, 32'h1);
        check_eq("ready_after_commit", {31'h0, in_ready}, 32'h1);

        // 5678 pending, ABCD held valid until accepted after commit
        write_value(16'h5678, 4'b0000);
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        got_it   = 1'b0;
        for (int k = 0; k < 64 && !got_it; k++) begin
            cyc(1);
            if (m_captured) got_it = 1'b1;
        end
        in_valid = 1'b0;
        check_eq("abcd_accepted", {31'h0, got_it}, 32'h1);
        check_eq("abcd_s0_old_frame", {28'h0, nibble}, 32'h8);
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_nib[s] = nibble;
        end
        check_eq("fabcd_s0", {28'h0, frame_nib[0]}, 32'hD);
        check_eq("fabcd_s1", {28'h0, frame_nib[1]}, 32'hC);
        check_eq("fabcd_s2", {28'h0, frame_nib[2]}, 32'hB);
        check_eq("fabcd_s3", {28'h0, frame_nib[3]}, 32'hA);

        // Mid-frame reset discards pending FFFF
        write_value(16'hFFFF, 4'b1111);
        cyc(2);
        do_reset();
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_nib[s] = nibble;
        end
        run_to_slot(0);
        check_eq("post_rst_s0", {28'h0, frame_nib[0]}, 32'h0);
        check_eq("post_rst_s3", {28'h0, frame_nib[3]}, 32'h0);
        check_eq("post_rst_dp", {31'h0, dp}, 32'h1);

        // Decimal point only on slot 2
        write_value(16'h1234, 4'b0100);
        run_to_slot(0);
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_dp[s] = dp;
        end
        check_eq("dp_s0", {31'h0, frame_dp[0]}, 32'h1);
        check_eq("dp_s1", {31'h0, frame_dp[1]}, 32'h1);
        check_eq("dp_s2", {31'h0, frame_dp[2]}, 32'h0);
        check_eq("dp_s3", {31'h0, frame_dp[3]}, 32'h1);

`ifdef SEG_LEADING_ZERO_BLANK_EN
        write_value(16'h0050, 4'b0000);
        run_to_slot(0);
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_nib[s] = nibble;
            frame_an[s]  = an;
        end
        check_eq("blk50_s0_nib", {28'h0, frame_nib[0]}, 32'h0);
        check_eq("blk50_s0_an", {28'h0, frame_an[0]}, 32'hE);
        check_eq("blk50_s1_nib", {28'h0, frame_nib[1]}, 32'h5);
        check_eq("blk50_s2_an", {28'h0, frame_an[2]}, 32'hF);
        check_eq("blk50_s3_an", {28'h0, frame_an[3]}, 32'hF);
        write_value(16'h0000, 4'b0000);
        run_to_slot(0);
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_an[s] = an;
        end
        check_eq("blk0_s0_an", {28'h0, frame_an[0]}, 32'hE);
        check_eq("blk0_s1_an", {28'h0, frame_an[1]}, 32'hF);
        check_eq("blk0_s2_an", {28'h0, frame_an[2]}, 32'hF);
        check_eq("blk0_s3_an", {28'h0, frame_an[3]}, 32'hF);
`else
        write_value(16'h0050, 4'b0000);
        run_to_slot(0);
        for (int s = 0; s < 4; s++) begin
            run_to_slot(s);
            frame_an[s] = an;
        end
        check_eq("noblk_s2_an", {28'h0, frame_an[2]}, 32'hB);
        check_eq("noblk_s3_an", {28'h0, frame_an[3]}, 32'h7);
`endif

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) in_data[15:8] = 8'h00;
            in_dp    = 4'($urandom);
            rst_n    = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and a synchronous, active-low reset, `rst_n`.
REQ-002 Parameter DIGITS, default 4, SHALL set the number of multiplexed digits.
REQ-003 Parameter REFRESH_DIV, default 100000, SHALL set the clk cycles per digit slot.
REQ-004 clk  input  1  is the system clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  is the synchronous active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that new display data is offered.
REQ-007 in_ready  output  1  SHALL indicate that the block can accept new data.
REQ-008 in_data  input  4*DIGITS  is the packed display value; digit i is in_data[4i+3:4i].
REQ-009 in_dp  input  DIGITS  is the decimal-point mask, active-high per digit.
REQ-010 nibble  output  4  is the current digit value, fed to the downstream hex-to-segment decoder.
REQ-011 an  output  DIGITS  is the digit enable, one-hot active-low.
REQ-012 dp  output  1  is the decimal point, active-low.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1, pulse an internal tick when the count equals REFRESH_DIV-1, and wrap to 0.
REQ-014 The digit index SHALL advance on each tick and wrap from DIGITS-1 to 0.
REQ-015 nibble, an and dp SHALL be registered and updated on the tick, reflecting the new index.
REQ-016 On each tick: an = all ones except bit[idx]=0; nibble = display[idx]; dp = ~dp_reg[idx].
REQ-017 in_ready SHALL equal !pending.
REQ-018 When in_valid & in_ready: in_data and in_dp SHALL be captured into the shadow registers and pending set, so in_ready is low from the next cycle.
REQ-019 While pending, in_valid SHALL be ignored, and the offered data SHALL NOT be captured.
REQ-020 On the tick that wraps the index from DIGITS-1 to 0 with pending set: display/dp_reg SHALL load from the shadow registers and pending SHALL clear in that same edge.
REQ-021 Tearing-free: a frame SHALL never mix old and new data; new data SHALL first appear at digit 0.
REQ-022 Capture requires !pending and commit requires pending, so the two SHALL never occur in the same cycle.

Reset
REQ-023 On rst_n=0 at a clk edge: prescaler=0, idx=DIGITS-1, display=0, dp_reg=0, shadow=0, pending=0.
REQ-024 In the same reset edge: an=all ones, nibble=0, dp=1, and in_ready=1 after the edge.
REQ-025 The first tick after reset SHALL select digit 0.
REQ-026 A mid-frame reset SHALL discard any pending data.

Configuration
REQ-027 With SEG_LEADING_ZERO_BLANK_EN defined: digit i>0 SHALL be blanked (an all ones for its slot) when display[DIGITS-1:i] are all zero; digit 0 SHALL never be blanked.
REQ-028 With SEG_LEADING_ZERO_BLANK_EN undefined: all digits SHALL always be shown; port list SHALL be identical in both builds.

Structure
REQ-029 A shared package SHALL hold the default DIGITS and REFRESH_DIV constants, and the nibble typedef (logic [3:0]).
REQ-030 The prescaler SHALL be a sub-module, scan_tick_gen (parameter REFRESH_DIV, output tick).
REQ-031 The hex-to-segment decoder SHALL stay outside this block, and nibble SHALL connect to it directly.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-032 Reset: check an=4'b1111, nibble=0, dp=1, in_ready=1; first tick at cycle 4 -> an=4'b1110, nibble=0.
REQ-033 Write 16'h1234 mid-frame -> in_ready=0 next cycle, old data until wrap; then slots 0..3 show nibble 4,3,2,1 and in_ready=1.
REQ-034 Second in_valid with 16'hABCD while pending -> not captured; held valid, it is accepted after commit, and the following frame shows D,C,B,A.
REQ-035 rst_n low 1 cycle mid-frame with pending 16'hFFFF -> all reset values; display stays 0.
REQ-036 With SEG_LEADING_ZERO_BLANK_EN, value 16'h0050 -> slots 3,2 show an=4'b1111, slot1 nibble 5, slot0 nibble 0; value 16'h0000 -> only slot 0 is lit.
REQ-037 in_dp=4'b0100 -> dp=0 only during slot 2, and dp=1 in all other slots.
